pifo_task_issuer: RTL and testbench

PIFO_TASK_ISSUER -- requirements
Module: pifo_task_issuer

---
 rtl/pifo_task_issuer.sv | 216 +++++++++++++++++++++
 tb/tb_pifo_task_issuer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_task_issuer.sv
// pifo_task_issuer: buffers push/pop requests for a set of PIFO trees and
// issues them one at a time to a shared port. A rejected op is retried after
// a fixed backoff and is dropped once it has been rejected ATTEMPT_MAX times.
// A pop waits POP_LAT cycles for the port to return data, then produces one
// response.
//
// Handshake: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both 1. o_req_ready depends only on the registered count,
// so a full FIFO refuses input even in a cycle where the head leaves.
// Port side: during an issue cycle the op is presented from registered state,
// and i_task_fail in that same cycle accepts (0) or rejects (1) it.
module pifo_task_issuer #(
    parameter int PTW         = 16,
    parameter int MTW         = 0,
    parameter int TREE_NUM    = 4,
    parameter int FIFO_SIZE   = 8,
    parameter int POP_LAT     = 2,
    parameter int BACKOFF     = 3,
    parameter int ATTEMPT_MAX = 4,
    localparam int DW = MTW + PTW,
    localparam int TW = $clog2(TREE_NUM),
    localparam int CW = $clog2(FIFO_SIZE + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    // request queue
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_op,
    input  logic [TW-1:0] i_req_tree_id,
    input  logic [DW-1:0] i_req_data,
    // port side
    output logic [TW-1:0] o_tree_id,
    output logic          o_push,
    output logic [DW-1:0] o_push_data,
    output logic          o_pop,
    input  logic          i_task_fail,
    input  logic [DW-1:0] i_pop_data,
    // responses and status
    output logic          o_rsp_valid,
    output logic [TW-1:0] o_rsp_tree_id,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_empty,
    output logic          o_drop,
    output logic [TW-1:0] o_drop_tree_id,
    output logic [CW-1:0] o_count,
    // debug view of the issue FSM
    output logic [1:0]    o_dbg_state
);

    localparam int AW = $clog2(FIFO_SIZE);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_SIZE);
    localparam logic [3:0]    ATT_LAST = 4'(ATTEMPT_MAX - 1);
    localparam logic [3:0]    WAIT_POP = 4'(POP_LAT);
    localparam logic [3:0]    WAIT_BO  = 4'(BACKOFF);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_BACKOFF  = 2'd2,
        S_POP_WAIT = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [3:0]    attempt_q;
    logic [3:0]    wait_cnt_q;
    logic [TW-1:0] pop_tree_q;

    logic          rsp_valid_q;
    logic [TW-1:0] rsp_tree_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_empty_q;
    logic          drop_q;
    logic [TW-1:0] drop_tree_q;

    logic          op_mem   [FIFO_SIZE];
    logic [TW-1:0] tree_mem [FIFO_SIZE];
    logic [DW-1:0] data_mem [FIFO_SIZE];

    logic          head_op;
    logic [TW-1:0] head_tree;
    logic [DW-1:0] head_data;
    logic          enq;
    logic          deq;
    logic          last_try;

    assign head_op   = op_mem[rd_ptr_q];
    assign head_tree = tree_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];

    assign o_req_ready = (count_q < FULL_CNT);
    assign enq         = i_req_valid & o_req_ready;
    // The head leaves on an accepted op or on its final rejected attempt.
    assign last_try    = (attempt_q == ATT_LAST);
    assign deq         = (state_q == S_ISSUE) & (~i_task_fail | last_try);

    // Occupancy after this edge; enqueue and dequeue together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Request storage; unread slots need no reset because the count gates reads.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            op_mem[wr_ptr_q]   <= i_req_op;
            tree_mem[wr_ptr_q] <= i_req_tree_id;
            data_mem[wr_ptr_q] <= i_req_data;
        end
    end

    // FIFO pointers (wrap naturally at the power-of-two depth) and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Port drive: only an ISSUE cycle presents the head entry.
    always_comb begin
        o_push      = 1'b0;
        o_pop       = 1'b0;
        o_tree_id   = '0;
        o_push_data = '0;
        if (state_q == S_ISSUE) begin
            o_push    = ~head_op;
            o_pop     = head_op;
            o_tree_id = head_tree;
            if (!head_op) o_push_data = head_data;
        end
    end

    // Issue FSM with retry/backoff, drop, pop latency and registered responses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            attempt_q   <= '0;
            wait_cnt_q  <= '0;
            pop_tree_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tree_q  <= '0;
            rsp_data_q  <= '0;
            rsp_empty_q <= 1'b0;
            drop_q      <= 1'b0;
            drop_tree_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!i_task_fail) begin
                        attempt_q <= '0;
                        if (head_op) begin
                            state_q    <= S_POP_WAIT;
                            wait_cnt_q <= WAIT_POP;
                            pop_tree_q <= head_tree;
                        end else begin
                            state_q <= (count_d != '0) ? S_ISSUE : S_IDLE;
                        end
                    end else if (last_try) begin
                        attempt_q   <= '0;
                        drop_q      <= 1'b1;
                        drop_tree_q <= head_tree;
                        state_q     <= (count_d != '0) ? S_ISSUE : S_IDLE;
                    end else begin
                        attempt_q  <= attempt_q + 4'd1;
                        wait_cnt_q <= WAIT_BO;
                        state_q    <= S_BACKOFF;
                    end
                end
                S_BACKOFF: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) state_q <= S_ISSUE;
                end
                S_POP_WAIT: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= i_pop_data;
                        rsp_tree_q  <= pop_tree_q;
                        rsp_empty_q <= &i_pop_data;
                        state_q     <= (count_d != '0) ? S_ISSUE : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_tree_id  = rsp_tree_q;
    assign o_rsp_data     = rsp_data_q;
    assign o_rsp_empty    = rsp_empty_q;
    assign o_drop         = drop_q;
    assign o_drop_tree_id = drop_tree_q;
    assign o_count        = count_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_pifo_task_issuer.sv
// Bench for pifo_task_issuer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_pifo_task_issuer;

  localparam int PTW = 16;
  localparam int MTW = 0;
  localparam int DW = 16;
  localparam int TREE_NUM = 4;
  localparam int TW = 2;
  localparam int FIFO_SIZE = 8;
  localparam int POP_LAT = 2;
  localparam int BACKOFF = 3;
  localparam int ATTEMPT_MAX = 4;
  localparam int CW = 4;

  // ---------------- clock / reset block ----------------
  logic clk;
  logic i_rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_op;
  logic [TW-1:0] i_req_tree_id;
  logic [DW-1:0] i_req_data;
  logic [TW-1:0] o_tree_id;
  logic          o_push;
  logic [DW-1:0] o_push_data;
  logic          o_pop;
  logic          i_task_fail;
  logic [DW-1:0] i_pop_data;
  logic          o_rsp_valid;
  logic [TW-1:0] o_rsp_tree_id;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_empty;
  logic          o_drop;
  logic [TW-1:0] o_drop_tree_id;
  logic [CW-1:0] o_count;
  logic [1:0]    o_dbg_state;

  pifo_task_issuer #(
    .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM), .FIFO_SIZE(FIFO_SIZE),
    .POP_LAT(POP_LAT), .BACKOFF(BACKOFF), .ATTEMPT_MAX(ATTEMPT_MAX)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
    .i_req_tree_id(i_req_tree_id), .i_req_data(i_req_data),
    .o_tree_id(o_tree_id), .o_push(o_push), .o_push_data(o_push_data), .o_pop(o_pop),
    .i_task_fail(i_task_fail), .i_pop_data(i_pop_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_tree_id(o_rsp_tree_id), .o_rsp_data(o_rsp_data),
    .o_rsp_empty(o_rsp_empty), .o_drop(o_drop), .o_drop_tree_id(o_drop_tree_id),
    .o_count(o_count), .o_dbg_state(o_dbg_state)
  );

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending entries in arrival order; vis is the first cycle the entry is
  // counted in occupancy.
  typedef struct {
    logic          op;
    logic [TW-1:0] tree;
    logic [DW-1:0] data;
    int            vis;
  } ent_t;
  ent_t model_q[$];

  int cyc = 0;          // index of the current cycle
  int last_busy = -100; // last cycle the port was occupied by an op, backoff or pop wait
  int attempts = 0;     // rejections seen by the current head
  bit started = 0;
  bit pend = 0;         // a pop response is on its way
  int pend_sample, pend_rsp;
  logic [TW-1:0] pend_tree;
  logic [DW-1:0] pend_data;
  bit drop_pend = 0;
  int drop_cyc;
  logic [TW-1:0] drop_tree_m;
  logic [TW-1:0] hold_rtree = '0;
  logic [DW-1:0] hold_rdata = '0;
  logic          hold_rempty = 1'b0;
  logic [TW-1:0] hold_dtree = '0;

  // expected outputs for the current cycle
  bit            exp_chk = 0;
  logic          exp_ready, exp_push, exp_pop, exp_rv, exp_rempty, exp_drop;
  logic [CW-1:0] exp_count;
  logic [TW-1:0] exp_tree, exp_rtree, exp_dtree;
  logic [DW-1:0] exp_pdata, exp_rdata;

  // ---------------- stimulus controls ----------------
  logic          d_rst = 1'b1;
  logic          d_valid = 1'b0;
  logic          d_op = 1'b0;
  logic [TW-1:0] d_tree = '0;
  logic [DW-1:0] d_data = '0;
  logic          d_fail = 1'b0;
  bit            fail_once = 0;
  int            fail_pct = 0;
  bit            pd_force = 0;
  logic [DW-1:0] d_pop_data = '0;

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_op = 1'b0; i_req_tree_id = '0;
    i_req_data = '0; i_task_fail = 1'b0; i_pop_data = '0;
  end

  // One clock cycle: drive inputs, work out this cycle's expected outputs,
  // advance the model, and return mid-cycle so callers may inspect outputs.
  task automatic tick();
    bit   iss;
    bit   enq;
    logic fail;
    ent_t e;
    @(posedge clk); #1;
    if (!pd_force)
      d_pop_data = ($urandom_range(9, 0) == 0) ? 16'hFFFF : DW'($urandom);

    exp_count = CW'(model_q.size());
    exp_ready = (model_q.size() < FIFO_SIZE);
    iss = 0;
    if (model_q.size() > 0 && cyc > last_busy) begin
      // visible for a full cycle, or arriving just as the port frees up
      if (model_q[0].vis <= cyc - 1 || (model_q[0].vis == cyc && cyc == last_busy + 1))
        iss = 1;
    end
    exp_push  = iss && !model_q[0].op;
    exp_pop   = iss && model_q[0].op;
    exp_tree  = iss ? model_q[0].tree : '0;
    exp_pdata = (iss && !model_q[0].op) ? model_q[0].data : '0;
    exp_rv = pend && (cyc == pend_rsp);
    if (exp_rv) begin
      hold_rdata  = pend_data;
      hold_rtree  = pend_tree;
      hold_rempty = (pend_data == 16'hFFFF);
    end
    exp_rdata  = hold_rdata;
    exp_rtree  = hold_rtree;
    exp_rempty = hold_rempty;
    exp_drop = drop_pend && (cyc == drop_cyc);
    if (exp_drop) hold_dtree = drop_tree_m;
    exp_dtree = hold_dtree;
    exp_chk = started;

    fail = d_fail;
    if (fail_once && iss) begin fail = 1'b1; fail_once = 0; end
    if (fail_pct > 0 && $urandom_range(99, 0) < fail_pct) fail = 1'b1;

    i_rst = d_rst; i_req_valid = d_valid; i_req_op = d_op; i_req_tree_id = d_tree;
    i_req_data = d_data; i_task_fail = fail; i_pop_data = d_pop_data;

    if (exp_rv) pend = 0;
    if (exp_drop) drop_pend = 0;
    if (d_rst) begin
      model_q.delete();
      pend = 0; drop_pend = 0; attempts = 0; last_busy = cyc;
      hold_rdata = '0; hold_rtree = '0; hold_rempty = 1'b0; hold_dtree = '0;
      started = 1;
    end else begin
      enq = d_valid && (model_q.size() < FIFO_SIZE);
      if (pend && cyc == pend_sample) pend_data = d_pop_data;
      if (iss) begin
        if (!fail) begin
          attempts = 0;
          if (model_q[0].op) begin
            pend = 1; pend_sample = cyc + POP_LAT; pend_rsp = cyc + POP_LAT + 1;
            pend_tree = model_q[0].tree;
            last_busy = cyc + POP_LAT;
          end else begin
            last_busy = cyc;
          end
          void'(model_q.pop_front());
        end else begin
          attempts++;
          if (attempts < ATTEMPT_MAX) begin
            last_busy = cyc + BACKOFF;
          end else begin
            attempts = 0;
            drop_pend = 1; drop_cyc = cyc + 1; drop_tree_m = model_q[0].tree;
            last_busy = cyc;
            void'(model_q.pop_front());
          end
        end
      end
      if (enq) begin
        e.op = d_op; e.tree = d_tree; e.data = d_data; e.vis = cyc + 1;
        model_q.push_back(e);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- scoreboard compare process ----------------
  always @(negedge clk) begin
    if (exp_chk) begin
      chk("ready",     32'(o_req_ready),    32'(exp_ready));
      chk("count",     32'(o_count),        32'(exp_count));
      chk("push",      32'(o_push),         32'(exp_push));
      chk("pop",       32'(o_pop),          32'(exp_pop));
      chk("tree_id",   32'(o_tree_id),      32'(exp_tree));
      chk("push_data", 32'(o_push_data),    32'(exp_pdata));
      chk("rsp_valid", 32'(o_rsp_valid),    32'(exp_rv));
      chk("rsp_tree",  32'(o_rsp_tree_id),  32'(exp_rtree));
      chk("rsp_data",  32'(o_rsp_data),     32'(exp_rdata));
      chk("rsp_empty", 32'(o_rsp_empty),    32'(exp_rempty));
      chk("drop",      32'(o_drop),         32'(exp_drop));
      chk("drop_tree", 32'(o_drop_tree_id), 32'(exp_dtree));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic set_req(input logic op, input logic [TW-1:0] tree, input logic [DW-1:0] data);
    d_valid = 1'b1; d_op = op; d_tree = tree; d_data = data;
  endtask

  // Pop issued from idle; returns after the response cycle has been checked.
  task automatic do_pop(input logic [TW-1:0] tree, input logic [DW-1:0] pd, input logic empty);
    set_req(1'b1, tree, DW'($urandom));
    tick(); d_valid = 1'b0;
    tick();
    tick(); chk("pop_issue", 32'(o_pop), 32'd1); chk("pop_tree", 32'(o_tree_id), 32'(tree));
    chk("pop_pdata", 32'(o_push_data), 32'd0);
    tick(); chk("pop_wait_nop", 32'(o_pop), 32'd0);
    pd_force = 1; d_pop_data = pd;
    tick(); pd_force = 0; chk("pop_early_rsp", 32'(o_rsp_valid), 32'd0);
    tick();
    chk("rsp_at_lat", 32'(o_rsp_valid), 32'd1);
    chk("rsp_data_lit", 32'(o_rsp_data), 32'(pd));
    chk("rsp_tree_lit", 32'(o_rsp_tree_id), 32'(tree));
    chk("rsp_empty_lit", 32'(o_rsp_empty), 32'(empty));
    tick(); chk("rsp_pulse", 32'(o_rsp_valid), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int issues, drops, cnt_at_drop;
    logic [TW-1:0] dtree;

    d_rst = 1'b1; tick(); tick(); d_rst = 1'b0;
    tick();
    chk("reset_ready", 32'(o_req_ready), 32'd1);
    chk("reset_count", 32'(o_count), 32'd0);
    chk("reset_rsp", 32'(o_rsp_valid), 32'd0);
    chk("reset_rdata", 32'(o_rsp_data), 32'd0);
    chk("reset_drop", 32'(o_drop), 32'd0);

    // single push
    set_req(1'b0, 2'd2, 16'h1234);
    tick(); d_valid = 1'b0;
    tick(); chk("push_cnt1", 32'(o_count), 32'd1); chk("push_not_yet", 32'(o_push), 32'd0);
    tick();
    chk("push_issue", 32'(o_push), 32'd1);
    chk("push_tree", 32'(o_tree_id), 32'd2);
    chk("push_data", 32'(o_push_data), 32'h1234);
    tick(); chk("push_cnt0", 32'(o_count), 32'd0); chk("push_done", 32'(o_push), 32'd0);

    // pops with data and with the empty marker
    do_pop(2'd1, 16'h00AB, 1'b0);
    do_pop(2'd1, 16'hFFFF, 1'b1);

    // one rejection, then retry after backoff
    set_req(1'b0, 2'd0, 16'hBEEF); fail_once = 1;
    tick(); d_valid = 1'b0;
    tick();
    tick(); chk("retry_first", 32'(o_push), 32'd1);
    for (int i = 0; i < BACKOFF; i++) begin
      tick(); chk("backoff_quiet", 32'(o_push | o_pop), 32'd0);
      chk("backoff_cnt", 32'(o_count), 32'd1);
    end
    tick(); chk("retry_again", 32'(o_push), 32'd1); chk("retry_data", 32'(o_push_data), 32'hBEEF);
    tick(); chk("retry_cnt0", 32'(o_count), 32'd0);

    // persistent rejection leads to a drop
    set_req(1'b0, 2'd3, 16'h5555);
    tick(); d_valid = 1'b0; d_fail = 1'b1;
    issues = 0; drops = 0; cnt_at_drop = -1; dtree = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_push) issues++;
      if (o_drop) begin drops++; dtree = o_drop_tree_id; cnt_at_drop = int'(o_count); end
    end
    d_fail = 1'b0;
    chk("drop_issues", 32'(issues), 32'd4);
    chk("drop_once", 32'(drops), 32'd1);
    chk("drop_tree_lit", 32'(dtree), 32'd3);
    chk("drop_count", 32'(cnt_at_drop), 32'd0);

    // fill under rejection, then simultaneous enqueue/dequeue at 7
    d_fail = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_req(1'b0, TW'($urandom), DW'($urandom));
      tick();
      if (i == 7) begin chk("fill_ready7", 32'(o_req_ready), 32'd1); chk("fill_cnt7", 32'(o_count), 32'd7); end
      if (i == 8) begin chk("full_ready", 32'(o_req_ready), 32'd0); chk("full_cnt", 32'(o_count), 32'd8); end
    end
    d_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    d_fail = 1'b0; set_req(1'b0, 2'd1, 16'h7777);
    tick();
    chk("full_drop", 32'(o_drop), 32'd1);
    chk("after_drop_cnt", 32'(o_count), 32'd7);
    chk("after_drop_issue", 32'(o_push), 32'd1);
    d_valid = 1'b0;
    tick(); chk("enq_deq_cnt", 32'(o_count), 32'd7);
    for (int i = 0; i < 12; i++) tick();
    chk("drained", 32'(o_count), 32'd0);

    // reset during a pop wait with entries queued
    set_req(1'b1, 2'd0, 16'h0);
    tick();
    for (int i = 0; i < 3; i++) begin set_req(1'b0, TW'(i), DW'($urandom)); tick(); end
    d_valid = 1'b0; d_rst = 1'b1;
    tick(); chk("prereset_cnt", 32'(o_count), 32'd3); chk("prereset_wait", 32'(o_pop | o_push), 32'd0);
    d_rst = 1'b0;
    tick();
    chk("rst_cnt", 32'(o_count), 32'd0);
    chk("rst_rsp", 32'(o_rsp_valid), 32'd0);
    chk("rst_port", 32'({o_push, o_pop, o_tree_id, o_push_data}), 32'd0);
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin tick(); chk("rst_no_rsp", 32'(o_rsp_valid), 32'd0); end

    // randomized traffic at several rejection rates
    for (int ph = 0; ph < 3; ph++) begin
      fail_pct = (ph == 0) ? 0 : (ph == 1) ? 15 : 40;
      for (int i = 0; i < 700; i++) begin
        d_valid = ($urandom_range(99, 0) < 60);
        d_op = $urandom_range(1, 0);
        d_tree = TW'($urandom);
        d_data = DW'($urandom);
        d_rst = ($urandom_range(399, 0) == 0);
        tick();
      end
    end
    fail_pct = 0; d_valid = 1'b0; d_rst = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("final_drain", 32'(o_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
